// File: rtl/abs_value.sv
// Combinational absolute value of a signed sample, returned as an unsigned
// value of the same width, so the most negative input maps to 2^(WIDTH-1).
module abs_value #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] data_i,
    output logic        [WIDTH-1:0] mag_o
);

    logic [WIDTH-1:0] raw;

    assign raw = data_i;
    // Unsigned negate: -2^(WIDTH-1) comes out as 2^(WIDTH-1), with no saturation.
    assign mag_o = raw[WIDTH-1] ? (~raw + {{(WIDTH-1){1'b0}}, 1'b1}) : raw;

endmodule

// File: rtl/abs_threshold_hyst.sv
// Registered magnitude detector with hysteresis: sets at |x| >= 2^BIT_HIGH,
// clears at |x| < 2^BIT_LOW, and holds in between.
module abs_threshold_hyst #(
    parameter int IN_WIDTH = 16,
    parameter int BIT_HIGH = 9,
    parameter int BIT_LOW  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] inData,
    output logic                hystDetect
);

    if (IN_WIDTH < 2 || BIT_LOW < 0 || BIT_LOW > BIT_HIGH || BIT_HIGH > IN_WIDTH - 1) begin : g_bad_params
        $error("abs_threshold_hyst: illegal IN_WIDTH/BIT_HIGH/BIT_LOW combination");
    end

    logic [IN_WIDTH-1:0] mag;
    logic                set_c;
    logic                above_low_c;
    logic                clear_c;
    logic                hyst_d;
    logic                hyst_q = 1'b0;

    abs_value #(
        .WIDTH(IN_WIDTH)
    ) u_abs (
        .data_i(inData),
        .mag_o (mag)
    );

    // Thresholds are powers of two, so each test is an OR over the upper bits.
    always_comb begin
        set_c       = 1'b0;
        above_low_c = 1'b0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i >= BIT_HIGH) set_c       = set_c | mag[i];
            if (i >= BIT_LOW)  above_low_c = above_low_c | mag[i];
        end
        clear_c = ~above_low_c;
    end

    always_comb begin
        hyst_d = hyst_q;
        if (set_c) begin
            hyst_d = 1'b1;
        end else if (clear_c) begin
            hyst_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hyst_q <= 1'b0;
        end else begin
            hyst_q <= hyst_d;
        end
    end

    assign hystDetect = hyst_q;

endmodule

// File: tb/tb_abs_threshold_hyst.sv
// Directed bench for abs_threshold_hyst (16-bit, set 512, clear 256) with an
// arithmetic reference model compared on every falling edge.
module tb_abs_threshold_hyst;

  localparam int W = 16;
  localparam int SET_T = 512;
  localparam int CLR_T = 256;

  logic         clk;
  logic         rst;
  logic [W-1:0] inData;
  logic         hystDetect;

  int n_total;
  int n_pass;
  logic model_q = 1'b0;
  logic pos_seq[2048];
  int   rise_at;
  int   fall_at;
  int   ones;
  int   seq_diff;
  int   rises;
  int   falls;
  logic prev;

  abs_threshold_hyst #(
    .IN_WIDTH(W),
    .BIT_HIGH(9),
    .BIT_LOW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inData(inData),
    .hystDetect(hystDetect)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: detector rule stated in plain arithmetic
  function automatic logic model_next(input logic prev_v, input int sample);
    int m;
    m = (sample < 0) ? -sample : sample;
    if (m >= SET_T) return 1'b1;
    if (m < CLR_T) return 1'b0;
    return prev_v;
  endfunction

  always @(posedge clk) begin
    int s;
    s = $signed(inData);
    model_q <= rst ? 1'b0 : model_next(model_q, s);
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // compare process: every cycle
  always @(negedge clk) begin
    check("model", int'(hystDetect), int'(model_q));
  end

  // driver
  task automatic step(input logic r, input int v);
    rst = r;
    inData = v[W-1:0];
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    rst = 1'b1;
    inData = '0;

    // reset held with a large input
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1000);
      check("reset_hold", int'(hystDetect), 0);
    end
    step(1'b0, 0);
    check("reset_release", int'(hystDetect), 0);

    // positive ramp up then down
    rise_at = -1;
    ones = 0;
    for (int v = 0; v <= 1023; v++) begin
      step(1'b0, v);
      pos_seq[v] = hystDetect;
      if (hystDetect) ones++;
      if (hystDetect && rise_at < 0) rise_at = v;
    end
    check("pos_rise_at", rise_at, 512);
    check("pos_ones_up", ones, 512);
    fall_at = -1;
    for (int v = 1023; v >= 0; v--) begin
      step(1'b0, v);
      pos_seq[2047 - v] = hystDetect;
      if (!hystDetect && fall_at < 0) fall_at = v;
    end
    check("pos_fall_at", fall_at, 255);

    // negative mirror
    rise_at = 1;
    seq_diff = 0;
    for (int v = 0; v <= 1023; v++) begin
      step(1'b0, -v);
      if (hystDetect !== pos_seq[v]) seq_diff++;
      if (hystDetect && rise_at > 0) rise_at = -v;
    end
    check("neg_rise_at", rise_at, -512);
    fall_at = 1;
    for (int v = 1023; v >= 0; v--) begin
      step(1'b0, -v);
      if (hystDetect !== pos_seq[2047 - v]) seq_diff++;
      if (!hystDetect && fall_at > 0) fall_at = -v;
    end
    check("neg_fall_at", fall_at, -255);
    check("mirror_seq_diff", seq_diff, 0);

    // most negative sample, hold band, clear
    step(1'b0, -32768);
    check("min_neg_set", int'(hystDetect), 1);
    step(1'b0, 300);
    check("hold_300", int'(hystDetect), 1);
    step(1'b0, 100);
    check("clear_100", int'(hystDetect), 0);

    // boundary values
    step(1'b0, 511);
    check("b511_hold0", int'(hystDetect), 0);
    step(1'b0, -512);
    check("bm512_set", int'(hystDetect), 1);
    step(1'b0, 256);
    check("b256_hold1", int'(hystDetect), 1);
    step(1'b0, -255);
    check("bm255_clear", int'(hystDetect), 0);

    // mid-operation reset
    step(1'b0, 600);
    check("set_600", int'(hystDetect), 1);
    step(1'b1, 600);
    check("rst_mid", int'(hystDetect), 0);
    step(1'b0, 600);
    check("after_rst_600", int'(hystDetect), 1);
    step(1'b0, 0);
    check("clear_0", int'(hystDetect), 0);

    // noisy sweep 0 -> 1023 -> -1024 -> 0: exactly two rises and two falls
    rises = 0;
    falls = 0;
    prev = hystDetect;
    for (int b = 0; b <= 1023; b += 2) begin
      step(1'b0, b + int'($urandom_range(0, 126)) - 63);
      if (hystDetect && !prev) rises++;
      if (!hystDetect && prev) falls++;
      prev = hystDetect;
    end
    for (int b = 1023; b >= -1024; b -= 2) begin
      step(1'b0, b + int'($urandom_range(0, 126)) - 63);
      if (hystDetect && !prev) rises++;
      if (!hystDetect && prev) falls++;
      prev = hystDetect;
    end
    for (int b = -1024; b <= 0; b += 2) begin
      step(1'b0, b + int'($urandom_range(0, 126)) - 63);
      if (hystDetect && !prev) rises++;
      if (!hystDetect && prev) falls++;
      prev = hystDetect;
    end
    step(1'b0, 0);
    if (hystDetect && !prev) rises++;
    if (!hystDetect && prev) falls++;
    check("noisy_rises", rises, 2);
    check("noisy_falls", falls, 2);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/abs_threshold_hyst.md
ABS_THRESHOLD_HYST -- requirements
Module: abs_threshold_hyst

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 16, the width of the signed input sample.
REQ-002 The block SHALL have parameter BIT_HIGH, default 9; the set threshold is 2^BIT_HIGH.
REQ-003 The block SHALL have parameter BIT_LOW, default 8; the clear threshold is 2^BIT_LOW.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port inData, input, IN_WIDTH bits, signed two's-complement sample, one sample per clock.
REQ-007 The block SHALL have port hystDetect, output, 1 bit, registered detect flag.

Function
REQ-008 Magnitude SHALL be computed as mag = |inData|, an IN_WIDTH-bit unsigned value; -2^(IN_WIDTH-1) SHALL give mag = 2^(IN_WIDTH-1), with no saturation and no wrap to a negative value.
REQ-009 The set condition SHALL be mag >= 2^BIT_HIGH, i.e. any bit of mag at index >= BIT_HIGH is 1.
REQ-010 The clear condition SHALL be mag < 2^BIT_LOW, i.e. all bits of mag at index >= BIT_LOW are 0.
REQ-011 On each rising clk edge with rst low: set condition -> hystDetect <= 1; else clear condition -> hystDetect <= 0; else hystDetect SHALL hold its value.
REQ-012 Latency SHALL be exactly one clock: hystDetect after edge N reflects inData sampled at edge N and the state before edge N; there is no combinational path from inData to hystDetect.
REQ-013 The comparison SHALL be symmetric in sign: +x and -x SHALL produce identical hystDetect sequences.
REQ-014 Boundaries: mag = 2^BIT_HIGH SHALL set; mag = 2^BIT_HIGH-1 SHALL hold; mag = 2^BIT_LOW SHALL hold; mag = 2^BIT_LOW-1 SHALL clear.
REQ-015 With BIT_LOW == BIT_HIGH the block SHALL act as a plain registered comparator with no hold band.
REQ-016 Legal parameters SHALL be 0 <= BIT_LOW <= BIT_HIGH <= IN_WIDTH-1 and IN_WIDTH >= 2; other values SHALL fail elaboration.

Reset
REQ-017 While rst is high at a rising clk edge, hystDetect SHALL become 0 regardless of inData.
REQ-018 On the first edge with rst low, the normal rule (REQ-011) SHALL apply from state 0; a mid-operation reset SHALL clear a set detector in one edge.
REQ-019 No other state SHALL exist; without reset the power-up value SHALL be 0 in simulation.

Structure
REQ-020 The block SHALL be a single module with no shared package; thresholds are derived locally from the parameters.
REQ-021 The magnitude computation SHALL be one natural sub-module, abs_value (parameter WIDTH, signed in, unsigned WIDTH-bit out, combinational).
REQ-022 Threshold tests SHALL be implemented as bit-range OR reductions, not general comparators.

Verification (IN_WIDTH=16, BIT_HIGH=9, BIT_LOW=8)
REQ-023 rst=1 with inData=1000 for 3 cycles -> hystDetect=0 throughout; release rst with inData=0 -> stays 0.
REQ-024 Ramp inData 0..1023 step 1 -> hystDetect rises on the edge sampling 512 and not before; ramp down 1023..0 -> falls on the edge sampling 255; values 256..511 hold.
REQ-025 Negative mirror, inData -1023..0 -> set at -512, clear at -255; the sequence is identical to the positive ramp.
REQ-026 inData=-32768 -> hystDetect=1 after one edge; then 300 -> 1 (hold); then 100 -> 0.
REQ-027 Ramp 0..1023..-1024..0 with uniform noise +/-63 added -> at most one 0->1 and one 1->0 transition per threshold crossing region; flag checked each cycle against a reference model of REQ-011.
REQ-028 Set the detector with 600, assert rst for one edge with inData=600, deassert -> 0 after the reset edge, 1 one edge later.
